// File: rtl/cf_math_pkg.sv
// cf_math_pkg: shared arithmetic helpers for parameterised RTL.
//
// idx_width(n) returns the number of bits needed to index n items. It is
// never less than 1, so a one-item set still gets a usable index port.
package cf_math_pkg;

    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
    endfunction

endpackage

// File: rtl/fall_through_register.sv
// fall_through_register: one-entry stream buffer with combinational pass-through.
//
// When the slot is empty, an incoming beat is visible on the output in the
// same cycle. If the consumer takes it in that cycle, nothing is stored.
// Otherwise the beat is captured and held until it is popped. ready_o depends
// only on the slot state, so no combinational path runs from ready_i to ready_o.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   clr_i               synchronous flush of the stored beat
//   testmode_i          test mode (no effect in this implementation)
//   valid_i/ready_o/data_i   upstream stream
//   valid_o/ready_i/data_o   downstream stream
module fall_through_register #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic testmode_i,
    input  logic valid_i,
    output logic ready_o,
    input  T     data_i,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o
);

    logic full_q, full_d;
    T     data_q, data_d;

    logic unused_testmode;
    assign unused_testmode = testmode_i;

    assign ready_o = ~full_q;
    assign valid_o = full_q | valid_i;
    assign data_o  = full_q ? data_q : data_i;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clr_i) begin
            full_d = 1'b0;
        end else if (full_q) begin
            // Full slot: ready_o is low, so only a pop can change the state.
            if (ready_i) begin
                full_d = 1'b0;
            end
        end else if (valid_i && !ready_i) begin
            // Empty slot, beat not taken straight through: keep it.
            full_d = 1'b1;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= T'('0);
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/stream_ft_rr_arbiter.sv
// stream_ft_rr_arbiter: round-robin arbiter sharing one output stream among
// NumIn requesters, each decoupled by its own fall-through register.
//
// A beat presented on valid_o is held (data_o and idx_o stable) until ready_i
// accepts it. The priority pointer moves past the granted requester on each
// handshake. Optional macro STREAM_FT_RR_ARBITER_BURST_EN lets a requester keep
// priority for up to MaxBurst consecutive beats.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clr_i                synchronous clear of buffers and arbiter state
//   testmode_i           forwarded to the buffers
//   valid_i/ready_o/data_i   per-requester input streams (NumIn wide)
//   valid_o/ready_i/data_o   shared output stream
//   idx_o                granted requester (priority pointer when idle)
module stream_ft_rr_arbiter
    import cf_math_pkg::*;
#(
    parameter int unsigned NumIn    = 4,
    parameter type         T        = logic,
    parameter int unsigned MaxBurst = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clr_i,
    input  logic                          testmode_i,
    input  logic [NumIn-1:0]              valid_i,
    output logic [NumIn-1:0]              ready_o,
    input  T     [NumIn-1:0]              data_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output T                              data_o,
    output logic [idx_width(NumIn)-1:0]   idx_o
);

    typedef logic [idx_width(NumIn)-1:0] idx_t;

    localparam int N = int'(NumIn);

    // Rotate req so the pointer sits at bit 0, take the lowest set bit, then
    // rotate the position back. Returns ptr when nothing is requesting.
    function automatic idx_t first_req(input logic [NumIn-1:0] req, input idx_t ptr);
        logic [NumIn-1:0] rot;
        int               pos;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[idx_t'((int'(ptr) + i) % N)];
        end
        pos = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = i;
            end
        end
        return idx_t'((int'(ptr) + pos) % N);
    endfunction

    logic [NumIn-1:0] req;
    logic [NumIn-1:0] pop;
    T     [NumIn-1:0] buf_data;

    logic rr_unused_ok;
    idx_t rr_q, rr_d;
    logic lock_q, lock_d;
    idx_t idx_q, idx_d;
    idx_t gnt;
    idx_t gnt_inc;
    logic hs;

    assign rr_unused_ok = 1'b1;

    for (genvar gi = 0; gi < N; gi++) begin : gen_buf
        fall_through_register #(.T(T)) i_ftreg (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .clr_i      (clr_i),
            .testmode_i (testmode_i),
            .valid_i    (valid_i[gi]),
            .ready_o    (ready_o[gi]),
            .data_i     (data_i[gi]),
            .valid_o    (req[gi]),
            .ready_i    (pop[gi]),
            .data_o     (buf_data[gi])
        );

        assign pop[gi] = hs && (gnt == idx_t'(gi)) && !clr_i;
    end

    // A held grant always has its beat parked in the buffer, so the locked
    // state can drive valid_o high without consulting req.
    assign gnt     = lock_q ? idx_q : first_req(req, rr_q);
    assign valid_o = lock_q | (|req);
    assign hs      = valid_o & ready_i;
    assign data_o  = buf_data[gnt];
    assign idx_o   = valid_o ? gnt : rr_q;
    assign gnt_inc = (gnt == idx_t'(N - 1)) ? '0 : gnt + idx_t'(1);

`ifdef STREAM_FT_RR_ARBITER_BURST_EN
    localparam int BurstW = (MaxBurst > 32'd1) ? $clog2(MaxBurst) : 1;

    logic [BurstW-1:0] burst_q, burst_d;
    logic [BurstW-1:0] burst_base;

    // burst_q is only meaningful while rr_q still points at the requester
    // that earned it; a grant to anyone else starts a fresh run.
    assign burst_base = (gnt == rr_q) ? burst_q : '0;
`else
    localparam int unsigned unused_max_burst = MaxBurst;
`endif

    always_comb begin
        rr_d   = rr_q;
        lock_d = lock_q;
        idx_d  = idx_q;
`ifdef STREAM_FT_RR_ARBITER_BURST_EN
        burst_d = burst_q;
`endif
        if (!lock_q && valid_o && !ready_i) begin
            lock_d = 1'b1;
            idx_d  = gnt;
        end
        if (hs) begin
            lock_d = 1'b0;
`ifdef STREAM_FT_RR_ARBITER_BURST_EN
            if ((int'(burst_base) + 1) < int'(MaxBurst)) begin
                rr_d    = gnt;
                burst_d = burst_base + BurstW'(1);
            end else begin
                rr_d    = gnt_inc;
                burst_d = '0;
            end
`else
            rr_d = gnt_inc;
`endif
        end
        if (clr_i) begin
            rr_d   = '0;
            lock_d = 1'b0;
            idx_d  = '0;
`ifdef STREAM_FT_RR_ARBITER_BURST_EN
            burst_d = '0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q   <= '0;
            lock_q <= 1'b0;
            idx_q  <= '0;
`ifdef STREAM_FT_RR_ARBITER_BURST_EN
            burst_q <= '0;
`endif
        end else if (rr_unused_ok) begin
            rr_q   <= rr_d;
            lock_q <= lock_d;
            idx_q  <= idx_d;
`ifdef STREAM_FT_RR_ARBITER_BURST_EN
            burst_q <= burst_d;
`endif
        end
    end

endmodule

// File: tb/tb_stream_ft_rr_arbiter.sv
module tb_stream_ft_rr_arbiter;

    localparam int N  = 4;
    localparam int MB = 3;
`ifdef STREAM_FT_RR_ARBITER_BURST_EN
    localparam int EFF_MB = MB;
`else
    localparam int EFF_MB = 1;
`endif

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            clr_i;
    logic            testmode_i;
    logic [N-1:0]    valid_i;
    logic [N-1:0]    ready_o;
    logic [N-1:0][7:0] data_i;
    logic            valid_o;
    logic            ready_i;
    logic [7:0]      data_o;
    logic [1:0]      idx_o;

    always #5 clk = ~clk;

    stream_ft_rr_arbiter #(
        .NumIn    (N),
        .T        (logic [7:0]),
        .MaxBurst (MB)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .clr_i      (clr_i),
        .testmode_i (testmode_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_i     (data_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .idx_o      (idx_o)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model: each buffer is a queue holding at most one beat;
    // the arbiter is a pointer, an optional held grant, and a run counter
    // of consecutive beats given to the same requester.
    logic [7:0] m_q[N][$];
    int m_rr, m_lock, m_idx, m_last, m_run;

    bit         e_valid;
    int         e_g;
    int         e_idx;
    logic [7:0] e_data;
    logic [N-1:0] e_ready;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_q[k].delete();
        m_rr = 0; m_lock = 0; m_idx = 0; m_last = -1; m_run = 0;
    endtask

    task automatic model_eval();
        bit req [N];
        bit any;
        any = 0;
        for (int k = 0; k < N; k++) begin
            req[k] = (m_q[k].size() > 0) || valid_i[k];
            any |= req[k];
            e_ready[k] = (m_q[k].size() == 0);
        end
        e_g = m_rr;
        if (m_lock != 0) begin
            e_g = m_idx;
            e_valid = 1;
        end else begin
            e_valid = any;
            for (int i = N - 1; i >= 0; i--) begin
                if (req[(m_rr + i) % N]) e_g = (m_rr + i) % N;
            end
        end
        e_idx  = e_valid ? e_g : m_rr;
        e_data = (m_q[e_g].size() > 0) ? m_q[e_g][0] : data_i[e_g];
    endtask

    task automatic model_update();
        bit hs;
        if (clr_i) begin
            model_reset();
            return;
        end
        hs = e_valid && ready_i;
        for (int k = 0; k < N; k++) begin
            bit popk;
            popk = hs && (e_g == k);
            if (m_q[k].size() > 0) begin
                if (popk) void'(m_q[k].pop_front());
            end else if (valid_i[k] && !popk) begin
                m_q[k].push_back(data_i[k]);
            end
        end
        if (m_lock == 0 && e_valid && !ready_i) begin
            m_lock = 1;
            m_idx  = e_g;
        end
        if (hs) begin
            m_lock = 0;
            if (e_g == m_last) m_run++;
            else begin
                m_last = e_g;
                m_run  = 1;
            end
            if (m_run < EFF_MB) m_rr = e_g;
            else begin
                m_rr  = (e_g + 1) % N;
                m_run = 0;
            end
        end
    endtask

    // Called just after the falling edge, once inputs are driven.
    task automatic step();
        #1;
        model_eval();
        if (!clr_i) begin
            check("valid_o", int'(valid_o), int'(e_valid));
            check("idx_o", int'(idx_o), e_idx);
            check("ready_o", int'(ready_o), int'(e_ready));
            if (e_valid) check("data_o", int'(data_o), int'(e_data));
        end
        $display("[TB] t=%0t v_i=%b r_i=%b clr=%b -> v_o=%b idx=%0d d=%02h r_o=%b",
                 $time, valid_i, ready_i, clr_i, valid_o, idx_o, data_o, ready_o);
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clr_cycle();
        valid_i = '0; ready_i = 1'b0; clr_i = 1'b1;
        step();
        advance();
        clr_i = 1'b0;
    endtask

    task automatic reset_pulse();
        valid_i = '0; clr_i = 1'b0; ready_i = 1'b0;
        rst_ni  = 1'b0;
        #1;
        check("rst_valid", int'(valid_o), 0);
        check("rst_ready", int'(ready_o), 4'b1111);
        check("rst_idx", int'(idx_o), 0);
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0; clr_i = 1'b0; testmode_i = 1'b0;
        valid_i = '0; ready_i = 1'b0; data_i = '0;
        @(negedge clk);
        @(negedge clk);
        reset_pulse();

        // Fairness: all four inputs valid, output always ready.
        valid_i = 4'b1111; ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < N; k++) data_i[k] = 8'(k * 16 + i);
            step();
            check("fair_valid", int'(valid_o), 1);
            check("fair_idx", int'(idx_o), (i / EFF_MB) % N);
            advance();
        end
        clr_cycle();

        // Backpressure: input 2 holds a beat while input 1 arrives.
        valid_i = 4'b0100; data_i[2] = 8'hA5; data_i[1] = 8'h11; ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) valid_i = 4'b0010;
            if (c == 2) valid_i = 4'b0000;
            step();
            check("bp_valid", int'(valid_o), 1);
            check("bp_idx", int'(idx_o), 2);
            check("bp_data", int'(data_o), 8'hA5);
            advance();
        end
        ready_i = 1'b1;
        step();
        check("bp_hs_idx", int'(idx_o), 2);
        advance();
        step();
        check("bp_next_idx", int'(idx_o), 1);
        check("bp_next_data", int'(data_o), 8'h11);
        advance();
        clr_cycle();

        // Buffer full and release.
        valid_i = 4'b0001; data_i[0] = 8'h3C; ready_i = 1'b0;
        step();
        check("full_rdy_before", int'(ready_o[0]), 1);
        advance();
        valid_i = 4'b0000;
        step();
        check("full_rdy_low", int'(ready_o[0]), 0);
        advance();
        ready_i = 1'b1;
        step();
        check("full_pop_data", int'(data_o), 8'h3C);
        advance();
        step();
        check("full_rdy_back", int'(ready_o[0]), 1);
        check("full_empty", int'(valid_o), 0);
        advance();
        clr_cycle();

        // Clear while locked on input 3.
        valid_i = 4'b1000; data_i[3] = 8'h77; ready_i = 1'b0;
        step();
        advance();
        valid_i = 4'b0000;
        step();
        check("lock_idx", int'(idx_o), 3);
        advance();
        clr_cycle();
        step();
        check("clr_valid", int'(valid_o), 0);
        check("clr_ready", int'(ready_o), 4'b1111);
        check("clr_rr", int'(idx_o), 0);
        advance();

        // Two requesters: bursts of EFF_MB beats alternate.
        valid_i = 4'b0011; ready_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            data_i[0] = 8'(i); data_i[1] = 8'(8'h80 + i);
            step();
            check("burst_idx", int'(idx_o), (i / EFF_MB) % 2);
            advance();
        end

        // Randomised traffic against the model.
        for (int i = 0; i < 800; i++) begin
            if (i == 400) reset_pulse();
            valid_i = N'($urandom);
            for (int k = 0; k < N; k++) data_i[k] = 8'($urandom);
            ready_i = ($urandom_range(0, 9) < 7);
            clr_i   = ($urandom_range(0, 59) == 0);
            step();
            advance();
        end
        clr_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stream_ft_rr_arbiter.md
# stream_ft_rr_arbiter

Round-robin arbiter that shares one downstream stream port among `NumIn` requesters. Each requester is decoupled by its own `fall_through_register`, so every input has default-ready behaviour. The arbiter picks one buffered entry at a time and holds it stable until the downstream handshake completes. It sits between several independent producers and a single shared consumer, such as a memory port or an interconnect slave.

## Interface
Parameters:
- `NumIn`, default 4: number of requesters; must be ≥ 2.
- `T`, default `logic`: payload type.
- `MaxBurst`, default 4: maximum consecutive beats granted to one requester; must be ≥ 1; used only with `STREAM_FT_RR_ARBITER_BURST_EN`.

Ports:
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: asynchronous active-low reset.
- `clr_i`  in  1: synchronous clear; flushes buffers and arbiter state.
- `testmode_i`  in  1: test mode; passed to the buffers.
- `valid_i`  in  `NumIn`: per-requester valid.
- `ready_o`  out  `NumIn`: per-requester ready; equals NOT full of that requester's buffer.
- `data_i`  in  `NumIn` × `T`: per-requester payload.
- `valid_o`  out  1: output valid.
- `ready_i`  in  1: output ready.
- `data_o`  out  `T`: payload of the granted requester.
- `idx_o`  out  `idx_width(NumIn)`: index of the granted requester.

## Operation
- **Buffers.** Input k feeds buffer k: push = `valid_i[k]` AND NOT full; pop = (granted k) AND `valid_o` AND `ready_i`.
- **Request vector.** `req[k]` = buffer k not empty. Because the buffers fall through, a `valid_i` arriving at an empty buffer is visible in `req` in the same cycle.
- **Arbiter state:**
  - `rr_q`, the priority pointer.
  - `lock_q` and `idx_q`, the held grant.
  - `burst_q`, the burst counter (macro builds only).
- **State IDLE (`lock_q` = 0):**
  - Grant the first k with `req[k]` set, searching from `rr_q` upward with wrap-around.
  - `valid_o` = OR of `req`.
  - If `valid_o` is high and `ready_i` is low, move to LOCKED with `idx_q` = grant.
  - If the handshake completes, stay in IDLE and update the pointer.
- **State LOCKED:**
  - Grant = `idx_q`; `valid_o` = 1.
  - `data_o` and `idx_o` are stable until `ready_i` is high.
  - On handshake, return to IDLE and update the pointer.
- **Pointer update on handshake with grant g:** `rr_q` ← (g + 1) mod `NumIn`. Wrap-around is required: g = `NumIn`−1 gives 0.
- **Idle output values.** When `valid_o` is low, `idx_o` = `rr_q` and `data_o` is don't-care.
- **Clear.** `clr_i` has priority over everything. It flushes all buffers, sets `rr_q` = 0, `lock_q` = 0 and `burst_q` = 0, and drops any locked beat. No pop is signalled on a clear cycle.
- **Handshake rule.** `valid_o` never drops while it is unacknowledged, except on `clr_i` or reset.

## Timing
- **Reset values:** `valid_o` = 0, `ready_o` = all ones, `idx_o` = 0, `rr_q` = 0, `lock_q` = 0, `burst_q` = 0.
- **Latency.** Empty buffer and immediate grant: input to output in 0 cycles (combinational).
- **Throughput:**
  - `ready_o[k]` goes low the cycle after a push that was not popped in the same cycle.
  - The buffer accepts again in the cycle after its pop.
  - One beat per cycle overall when `ready_i` is held high.
- **Simultaneous events.** A push and pop on the same buffer in one cycle is legal: a full buffer pops, and the new beat is taken next cycle. Two requests arriving in the same cycle are resolved by `rr_q`.
- **Reset mid-operation.** Asynchronous reset clears all state immediately; in-flight beats are lost.

## Configuration
- **Macro `STREAM_FT_RR_ARBITER_BURST_EN` undefined:**
  - Pure round robin, one beat per grant.
  - `burst_q` is absent; `MaxBurst` is ignored.
- **Macro defined:**
  - On handshake with grant g, `burst_q` increments.
  - If `burst_q`+1 < `MaxBurst`, `rr_q` stays at g, so g keeps priority while it still has requests.
  - Otherwise `rr_q` ← g+1 and `burst_q` ← 0.
  - `burst_q` also resets whenever the grant changes to a different index.
  - `MaxBurst` = 1 behaves identically to the undefined build.

## Structure
- No new package. Index width comes from `cf_math_pkg::idx_width(NumIn)`.
- Local typedef `idx_t` = `logic [idx_width(NumIn)-1:0]`.
- Burst counter width is `$clog2(MaxBurst)`, minimum 1.
- Sub-module: `fall_through_register #(.T(T))`, instantiated `NumIn` times in a generate loop.
- Priority search is a rotate plus leading-one detector in a local function; no further sub-modules.

## Test plan
- **Reset:** `rst_ni` low → `valid_o` = 0, `ready_o` = 4'b1111, `idx_o` = 0.
- **Fairness:** `NumIn` = 4, all four inputs valid constantly, `ready_i` = 1 → `idx_o` sequence 0,1,2,3,0,… with one beat per cycle and no gaps.
- **Stability under backpressure:** input 2 only, data 0xA5, `ready_i` low for 3 cycles → `valid_o` = 1, `idx_o` = 2 and `data_o` = 0xA5 stable all 3 cycles. Input 1 raising valid meanwhile does not change the grant. Handshake on cycle 4, then `idx_o` = 1.
- **Buffer full:** input 0 valid with `ready_i` = 0 → `ready_o[0]` = 0 from the next cycle. Raise `ready_i` → pop, and `ready_o[0]` = 1 the following cycle.
- **Clear mid-lock:** locked on input 3, assert `clr_i` → next cycle `valid_o` = 0, all buffers empty, `rr_q` = 0.
- **Burst (macro defined, `MaxBurst` = 3):** inputs 0 and 1 continuously valid → `idx_o` sequence 0,0,0,1,1,1,0,…
